pll_lock_supervisor: RTL and testbench

Supervises the board PLL from the reference-clock side: drives the PLL `rst` input, consumes its asynchronous `locked` output, and produces a clean system reset that is released only after lock has been stable for a programmable time. It sits between the PLL wrapper and the rest of the test design. It retries on lock timeout and on loss of lock, and reports lock-loss statistics and a sticky failure flag for the GPIO test logic.

---
 rtl/pll_sup_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 23 ++
 rtl/pll_lock_supervisor.sv | 110 +++++++++++
 tb/tb_pll_lock_supervisor.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
package pll_sup_pkg;

    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } pll_state_t;

    // One timer serves every state, so it is sized for the longest interval.
    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with asynchronous active-low reset to zero.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Drives the PLL reset, waits for a stable lock and releases the system reset;
// retries on lock timeout or lock loss and keeps loss/failure statistics.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 1000000,
    parameter int STABLE_CYCLES = 65536,
    parameter int MAX_RETRIES   = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       locked,
    output logic       pll_rst,
    output logic       sys_reset_n,
    output logic [1:0] state,
    output logic [7:0] lock_lost_count,
    output logic       fail
);

    localparam int TW = timer_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int RW = $clog2(MAX_RETRIES + 1);

    localparam logic [TW-1:0] RST_LAST     = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] STABLE_LAST  = TW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRIES);

    pll_state_t    state_q;
    pll_state_t    state_d;
    logic [TW-1:0] timer_q;
    logic [RW-1:0] retry_q;
    logic          locked_s;
    logic          timeout;
    logic          lock_loss;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .d     (locked),
        .q     (locked_s)
    );

    // Lock is checked before the terminal counts so it wins any tie.
    always_comb begin
        state_d   = state_q;
        timeout   = 1'b0;
        lock_loss = 1'b0;
        case (state_q)
            RESET_PLL: begin
                if (timer_q == RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = STABLE;
                end else if (timer_q == TIMEOUT_LAST) begin
                    state_d = RESET_PLL;
                    timeout = 1'b1;
                end
            end
            STABLE: begin
                if (!locked_s) state_d = WAIT_LOCK;
                else if (timer_q == STABLE_LAST) state_d = RUN;
            end
            RUN: begin
                if (!locked_s) begin
                    state_d   = RESET_PLL;
                    lock_loss = 1'b1;
                end
            end
            default: state_d = RESET_PLL;
        endcase
    end

    // Outputs are registered from the next state so they change with it, glitch-free.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RESET_PLL;
            timer_q     <= '0;
            pll_rst     <= 1'b1;
            sys_reset_n <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= (state_d != state_q || state_q == RUN) ? '0 : timer_q + TW'(1);
            pll_rst     <= (state_d == RESET_PLL);
            sys_reset_n <= (state_d == RUN);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            retry_q         <= '0;
            fail            <= 1'b0;
            lock_lost_count <= '0;
        end else begin
            if (timeout) begin
                if (retry_q != RETRY_MAX) retry_q <= retry_q + RW'(1);
                if (retry_q >= RETRY_MAX - RW'(1)) fail <= 1'b1;
            end else if (state_q == STABLE && state_d == RUN) begin
                retry_q <= '0;
            end
            if (lock_loss && lock_lost_count != 8'hFF) begin
                lock_lost_count <= lock_lost_count + 8'd1;
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with a cycle-count reference model
// compared every cycle, plus literal latency and saturation checks.
module tb_pll_lock_supervisor;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 20;
    localparam int STABLE_CYCLES = 8;
    localparam int MAX_RETRIES   = 2;

    localparam int SIG_STATE = 0;
    localparam int SIG_PLL   = 1;
    localparam int SIG_SYS   = 2;
    localparam int SIG_FAIL  = 3;

    logic       clk;
    logic       reset_n;
    logic       locked;
    logic       pll_rst;
    logic       sys_reset_n;
    logic [1:0] state;
    logic [7:0] lock_lost_count;
    logic       fail;

    int tests_run;
    int tests_failed;
    int cyc;

    pll_lock_supervisor #(
        .RST_CYCLES    (RST_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .STABLE_CYCLES (STABLE_CYCLES),
        .MAX_RETRIES   (MAX_RETRIES)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .locked          (locked),
        .pll_rst         (pll_rst),
        .sys_reset_n     (sys_reset_n),
        .state           (state),
        .lock_lost_count (lock_lost_count),
        .fail            (fail)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic lock_val);
        locked = lock_val;
    endtask

    function automatic int sample(input int sig);
        case (sig)
            SIG_STATE: return int'(state);
            SIG_PLL:   return int'(pll_rst);
            SIG_SYS:   return int'(sys_reset_n);
            SIG_FAIL:  return int'(fail);
            default:   return -1;
        endcase
    endfunction

    // Bounded wait; an expired budget shows up as a failed comparison.
    task automatic waitFor(input int sig, input int val, input int budget, input string name);
        int n;
        n = 0;
        while (sample(sig) != val && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, sample(sig), val);
    endtask

    // Reference model: phase plus cycles spent in it; lock is seen two edges late.
    int m_phase;
    int m_elapsed;
    int m_retries;
    int m_losses;
    int m_fail;
    bit s1;
    bit s2;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_phase   = 0;
            m_elapsed = 0;
            m_retries = 0;
            m_losses  = 0;
            m_fail    = 0;
            s1        = 1'b0;
            s2        = 1'b0;
        end else begin
            int nxt;
            nxt = m_phase;
            m_elapsed++;
            case (m_phase)
                0: if (m_elapsed == RST_CYCLES) nxt = 1;
                1: begin
                    if (s2) nxt = 2;
                    else if (m_elapsed == LOCK_TIMEOUT) begin
                        nxt = 0;
                        if (m_retries < MAX_RETRIES) m_retries++;
                        if (m_retries == MAX_RETRIES) m_fail = 1;
                    end
                end
                2: begin
                    if (!s2) nxt = 1;
                    else if (m_elapsed == STABLE_CYCLES) begin
                        nxt = 3;
                        m_retries = 0;
                    end
                end
                default: begin
                    if (!s2) begin
                        nxt = 0;
                        if (m_losses < 255) m_losses++;
                    end
                end
            endcase
            if (nxt != m_phase) m_elapsed = 0;
            m_phase = nxt;
            s2 = s1;
            s1 = locked;
        end
    end

    always @(negedge clk) begin
        checkOutput("model_state", int'(state), m_phase);
        checkOutput("model_pll_rst", int'(pll_rst), (m_phase == 0) ? 1 : 0);
        checkOutput("model_sys_reset_n", int'(sys_reset_n), (m_phase == 3) ? 1 : 0);
        checkOutput("model_lock_lost_count", int'(lock_lost_count), m_losses);
        checkOutput("model_fail", int'(fail), m_fail);
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t0, l_edge, d, g, r1, r2, r3;
        tests_run    = 0;
        tests_failed = 0;
        cyc          = 0;
        reset_n      = 1'b0;
        applyStimulus(1'b0);
        repeat (3) @(negedge clk);

        checkOutput("reset_state", int'(state), 0);
        checkOutput("reset_pll_rst", int'(pll_rst), 1);
        checkOutput("reset_sys_reset_n", int'(sys_reset_n), 0);
        checkOutput("reset_lost_count", int'(lock_lost_count), 0);
        checkOutput("reset_fail", int'(fail), 0);

        reset_n = 1'b1;
        t0 = cyc;
        waitFor(SIG_PLL, 0, 20, "first_pll_rst_drop");
        checkOutput("first_pll_rst_width", cyc - t0, 4);

        while (cyc < t0 + 10) @(negedge clk);
        applyStimulus(1'b1);
        l_edge = cyc;
        waitFor(SIG_SYS, 1, 40, "first_release");
        checkOutput("lock_to_release", cyc - l_edge, 11);
        checkOutput("first_run_state", int'(state), 3);
        checkOutput("first_run_fail", int'(fail), 0);

        for (int i = 0; i < 3; i++) begin
            repeat (2) @(negedge clk);
            applyStimulus(1'b0);
            d = cyc;
            waitFor(SIG_SYS, 0, 10, "loss_sys_drop");
            checkOutput("loss_latency", cyc - d, 3);
            checkOutput("loss_pll_rst", int'(pll_rst), 1);
            applyStimulus(1'b1);
            waitFor(SIG_STATE, 3, 60, "loss_relock");
        end
        checkOutput("lost_count_3", int'(lock_lost_count), 3);
        checkOutput("loss_fail", int'(fail), 0);

        applyStimulus(1'b0);
        waitFor(SIG_STATE, 0, 10, "glitch_drop");
        applyStimulus(1'b1);
        waitFor(SIG_STATE, 2, 40, "glitch_stable");
        repeat (2) @(negedge clk);
        applyStimulus(1'b0);
        @(negedge clk);
        applyStimulus(1'b1);
        g = cyc;
        waitFor(SIG_STATE, 1, 5, "glitch_back_to_wait");
        waitFor(SIG_STATE, 2, 5, "glitch_restable");
        waitFor(SIG_SYS, 1, 30, "glitch_release");
        checkOutput("glitch_to_release", cyc - g, 11);

        applyStimulus(1'b0);
        d = cyc;
        waitFor(SIG_PLL, 1, 10, "hold_low_pll_rst1");
        r1 = cyc;
        checkOutput("hold_low_first_rise", r1 - d, 3);
        waitFor(SIG_PLL, 0, 10, "hold_low_pll_fall1");
        checkOutput("retry_width1", cyc - r1, 4);
        waitFor(SIG_PLL, 1, 30, "hold_low_pll_rst2");
        r2 = cyc;
        checkOutput("retry_period1", r2 - r1, 24);
        checkOutput("fail_after_timeout1", int'(fail), 0);
        waitFor(SIG_PLL, 0, 10, "hold_low_pll_fall2");
        checkOutput("retry_width2", cyc - r2, 4);
        waitFor(SIG_PLL, 1, 30, "hold_low_pll_rst3");
        r3 = cyc;
        checkOutput("retry_period2", r3 - r2, 24);
        checkOutput("fail_at_timeout2", int'(fail), 1);
        repeat (30) @(negedge clk);
        checkOutput("fail_sticky", int'(fail), 1);

        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b1);
            waitFor(SIG_STATE, 3, 80, "sat_relock");
            applyStimulus(1'b0);
            waitFor(SIG_STATE, 0, 10, "sat_drop");
        end
        checkOutput("lost_count_saturated", int'(lock_lost_count), 255);
        checkOutput("fail_after_saturation", int'(fail), 1);

        applyStimulus(1'b1);
        waitFor(SIG_STATE, 3, 80, "final_run");
        checkOutput("final_fail_set", int'(fail), 1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_reset_state", int'(state), 0);
        checkOutput("async_reset_pll_rst", int'(pll_rst), 1);
        checkOutput("async_reset_sys_reset_n", int'(sys_reset_n), 0);
        checkOutput("async_reset_lost_count", int'(lock_lost_count), 0);
        checkOutput("async_reset_fail", int'(fail), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
